hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS datapath. It drives the enable/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and resolves hazards by load-use stall, taken-branch flush and data-memory wait. It also produces forwarding selects for the EX-stage operand muxes and keeps saturating stall/flush statistics. It sits beside the pipeline registers and updates on the same clock edge they do.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/fwd_unit.sv | 29 ++
 rtl/hazard_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline control logic.
package pipe_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_RF  = 2'b00;
    localparam fwd_t FWD_MEM = 2'b10;
    localparam fwd_t FWD_WB  = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic [REG_W-1:0] i_mem_rw,
    input  logic             i_mem_regwr,
    input  logic [REG_W-1:0] i_wb_rw,
    input  logic             i_wb_regwr,
    output fwd_t             o_fwd
);

    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired zero, so a write to it must never be forwarded.
    assign w_mem_hit = i_mem_regwr && (i_mem_rw != '0) && (i_mem_rw == i_src);
    assign w_wb_hit  = i_wb_regwr  && (i_wb_rw  != '0) && (i_wb_rw  == i_src);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_mem_hit) begin
            o_fwd = FWD_MEM;
        end else if (w_wb_hit) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush enables, memory-wait FSM with
// timeout, forwarding selects and saturating stall/flush statistics.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_Rw,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic [REG_W-1:0] mem_Rw,
    input  logic             mem_RegWr,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_Rw,
    input  logic             wb_RegWr,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output fwd_t             fwdA,
    output fwd_t             fwdB,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_next;
    logic [WAIT_W:0]    w_wait_inc;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_mem_err;
    logic               w_memwait;
    logic               w_loaduse;
    logic               w_do_stall;
    logic               w_do_flush;

    assign w_memwait  = mem_req && !mem_ready;
    assign w_loaduse  = ex_MemtoReg && ex_RegWr && (ex_Rw != '0) &&
                        ((id_uses_rs && (id_rs == ex_Rw)) ||
                         (id_uses_rt && (id_rt == ex_Rw)));
    assign w_wait_inc = {1'b0, r_wait_cnt} + (WAIT_W+1)'(1);

    fwd_unit u_fwd_a (
        .i_src       (ex_rs),
        .i_mem_rw    (mem_Rw),
        .i_mem_regwr (mem_RegWr),
        .i_wb_rw     (wb_Rw),
        .i_wb_regwr  (wb_RegWr),
        .o_fwd       (fwdA)
    );

    fwd_unit u_fwd_b (
        .i_src       (ex_rt),
        .i_mem_rw    (mem_Rw),
        .i_mem_regwr (mem_RegWr),
        .i_wb_rw     (wb_Rw),
        .i_wb_regwr  (wb_RegWr),
        .o_fwd       (fwdB)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        pc_en           = 1'b1;
        ifid_en         = 1'b1;
        idex_en         = 1'b1;
        exmem_en        = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        memwb_flush     = 1'b0;
        w_do_stall      = 1'b0;
        w_do_flush      = 1'b0;

        if (rst) begin
            // Reset edge pending: present the free-running RUN controls.
        end else if (r_state == ERROR) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else begin
            if (w_memwait) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
                w_do_stall  = 1'b1;
            end else if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                w_do_flush  = 1'b1;
            end else if (w_loaduse) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_flush  = 1'b1;
                w_do_stall  = 1'b1;
            end

            case (r_state)
                RUN: begin
                    if (w_memwait) begin
                        w_state_next    = MEM_WAIT;
                        w_wait_cnt_next = WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        w_state_next    = RUN;
                        w_wait_cnt_next = '0;
                    end else if (w_wait_inc >= (WAIT_W+1)'(MEM_TIMEOUT)) begin
                        w_state_next    = ERROR;
                        w_wait_cnt_next = '0;
                    end else begin
                        w_wait_cnt_next = w_wait_inc[WAIT_W-1:0];
                    end
                end
                default: begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end
            endcase
        end
    end

    // Updates on the falling edge, together with the pipeline registers.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_mem_err  <= r_mem_err || (w_state_next == ERROR);
            if (w_do_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_do_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
